// File: rtl/des_spi_master.sv
// 64-bit mode-0 SPI master (CPOL=0, CPHA=0, MSB first) for the DES core's SPI slave port.
// Optional feature macro: DES_SPI_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module des_spi_master #(
  parameter int WORD_W  = 64,
  parameter int CLK_DIV = 5,
  parameter int CS_GAP  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] tx_data,
`ifdef DES_SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi
);

  localparam int CNT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BIT_W    = $clog2(WORD_W) + 1;
  // GAP is entered on the done edge, so it lasts one cycle less than the cs_n high time.
  localparam int GAP_LAST = (CS_GAP >= 2) ? CS_GAP - 2 : 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_shift_tx;
  logic [WORD_W-1:0] r_shift_rx;
  logic [WORD_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;

  logic w_div_end;
  logic w_gap_end;
  logic w_last_bit;
  logic w_rx_bit;

  assign w_div_end  = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(GAP_LAST));
  assign w_last_bit = (r_bit_cnt == BIT_W'(WORD_W));

`ifdef DES_SPI_LOOPBACK_EN
  logic r_loopback;
  assign w_rx_bit = r_loopback ? r_mosi : miso;
`else
  assign w_rx_bit = miso;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DES_SPI_LOOPBACK_EN
      r_loopback <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_state    <= S_SETUP;
            r_shift_tx <= tx_data;
            r_mosi     <= tx_data[WORD_W-1];
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
`ifdef DES_SPI_LOOPBACK_EN
            r_loopback <= loopback;
`endif
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_cnt      <= '0;
            r_sclk     <= 1'b1;
            r_shift_rx <= {r_shift_rx[WORD_W-2:0], w_rx_bit};
            r_bit_cnt  <= BIT_W'(1);
            r_state    <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_cnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              // mosi keeps the final bit after the last falling edge.
              if (!w_last_bit) begin
                r_mosi     <= r_shift_tx[WORD_W-2];
                r_shift_tx <= {r_shift_tx[WORD_W-2:0], 1'b0};
              end
            end else if (w_last_bit) begin
              r_state <= S_HOLD;
            end else begin
              r_sclk     <= 1'b1;
              r_shift_rx <= {r_shift_rx[WORD_W-2:0], w_rx_bit};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_cnt     <= '0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_rx_data <= r_shift_rx;
            r_done    <= 1'b1;
            r_state   <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;

endmodule
